// File: rtl/mbscore_alu_issue_pkg.sv
// Shared widths, ALU op codes, MIPS opcode/funct constants and the issue-entry
// record passed from the decoder into the skid buffer.
package mbscore_alu_issue_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int ALU_OP_WIDTH = 4;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD  = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADDU = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB  = 4'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUBU = 4'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND  = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR   = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR  = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_NOR  = 4'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL  = 4'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL  = 4'd9;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA  = 4'd10;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_EQ   = 4'd11;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_NE   = 4'd12;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_LT   = 4'd13;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_LTU  = 4'd14;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_NOP  = 4'hF;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   a;
    logic [DATA_WIDTH-1:0]   b;
    logic [ALU_OP_WIDTH-1:0] op;
    logic [4:0]              rd;
    logic                    wb_en;
    logic                    illegal;
  } issue_entry_t;

  // funct[1:0] selects the shift flavour for both immediate and variable shifts.
  function automatic logic [ALU_OP_WIDTH-1:0] shift_op(input logic [1:0] kind);
    case (kind)
      2'b10:   shift_op = ALU_OP_SRL;
      2'b11:   shift_op = ALU_OP_SRA;
      default: shift_op = ALU_OP_SLL;
    endcase
  endfunction

endpackage

// File: rtl/mbscore_inst_decode.sv
// Combinational MIPS decode: instruction plus rs/rt read data into one issue entry.
// Undecodable words become an illegal NOP entry with zero operands.
module mbscore_inst_decode
  import mbscore_alu_issue_pkg::*;
(
  input  logic [31:0]           instr_i,
  input  logic [DATA_WIDTH-1:0] rs_data_i,
  input  logic [DATA_WIDTH-1:0] rt_data_i,
  output issue_entry_t          entry_o
);

  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [DATA_WIDTH-1:0] imm_sext;
  logic [DATA_WIDTH-1:0] imm_zext;
  logic [DATA_WIDTH-1:0] shamt_zext;
  logic [DATA_WIDTH-1:0] rs_shamt_zext;
  logic                  legal;
  issue_entry_t          dec;

  assign opcode        = instr_i[31:26];
  assign funct         = instr_i[5:0];
  assign imm_sext      = {{(DATA_WIDTH-16){instr_i[15]}}, instr_i[15:0]};
  assign imm_zext      = {{(DATA_WIDTH-16){1'b0}}, instr_i[15:0]};
  assign shamt_zext    = {{(DATA_WIDTH-5){1'b0}}, instr_i[10:6]};
  assign rs_shamt_zext = {{(DATA_WIDTH-5){1'b0}}, rs_data_i[4:0]};

  always_comb begin
    dec    = '0;
    dec.op = ALU_OP_NOP;
    legal  = 1'b1;
    case (opcode)
      OPC_RTYPE: begin
        dec.a     = rs_data_i;
        dec.b     = rt_data_i;
        dec.rd    = instr_i[15:11];
        dec.wb_en = 1'b1;
        case (funct)
          FN_ADD:  dec.op = ALU_OP_ADD;
          FN_ADDU: dec.op = ALU_OP_ADDU;
          FN_SUB:  dec.op = ALU_OP_SUB;
          FN_SUBU: dec.op = ALU_OP_SUBU;
          FN_AND:  dec.op = ALU_OP_AND;
          FN_OR:   dec.op = ALU_OP_OR;
          FN_XOR:  dec.op = ALU_OP_XOR;
          FN_NOR:  dec.op = ALU_OP_NOR;
          FN_SLT:  dec.op = ALU_OP_LT;
          FN_SLTU: dec.op = ALU_OP_LTU;
          FN_SLL, FN_SRL, FN_SRA: begin
            dec.a  = rt_data_i;
            dec.b  = shamt_zext;
            dec.op = shift_op(funct[1:0]);
          end
          FN_SLLV, FN_SRLV, FN_SRAV: begin
            dec.a  = rt_data_i;
            dec.b  = rs_shamt_zext;
            dec.op = shift_op(funct[1:0]);
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_ADDI, OPC_ADDIU, OPC_SLTI, OPC_SLTIU,
      OPC_ANDI, OPC_ORI, OPC_XORI: begin
        dec.a     = rs_data_i;
        dec.rd    = instr_i[20:16];
        dec.wb_en = 1'b1;
        case (opcode)
          OPC_ADDI:  begin dec.op = ALU_OP_ADD;  dec.b = imm_sext; end
          OPC_ADDIU: begin dec.op = ALU_OP_ADDU; dec.b = imm_sext; end
          OPC_SLTI:  begin dec.op = ALU_OP_LT;   dec.b = imm_sext; end
          OPC_SLTIU: begin dec.op = ALU_OP_LTU;  dec.b = imm_sext; end
          OPC_ANDI:  begin dec.op = ALU_OP_AND;  dec.b = imm_zext; end
          OPC_ORI:   begin dec.op = ALU_OP_OR;   dec.b = imm_zext; end
          default:   begin dec.op = ALU_OP_XOR;  dec.b = imm_zext; end
        endcase
      end
      OPC_LUI: begin
        // LUI is executed as a left shift of the immediate by 16.
        dec.a     = imm_zext;
        dec.b     = DATA_WIDTH'(16);
        dec.op    = ALU_OP_SLL;
        dec.rd    = instr_i[20:16];
        dec.wb_en = 1'b1;
      end
      OPC_BEQ, OPC_BNE: begin
        dec.a  = rs_data_i;
        dec.b  = rt_data_i;
        dec.op = (opcode == OPC_BEQ) ? ALU_OP_EQ : ALU_OP_NE;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec         = '0;
      dec.op      = ALU_OP_NOP;
      dec.illegal = 1'b1;
    end
    if (dec.rd == 5'd0) dec.wb_en = 1'b0;
  end

  assign entry_o = dec;

endmodule

// File: rtl/mbscore_alu_issue.sv
// Decode/issue stage feeding the ALU: 2-entry skid buffer whose head drives the
// ALU inputs, with a NOP cycle inserted between back-to-back identical op codes.
module mbscore_alu_issue
  import mbscore_alu_issue_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  output logic [4:0]              rs_addr,
  output logic [4:0]              rt_addr,
  input  logic [DATA_WIDTH-1:0]   rs_data,
  input  logic [DATA_WIDTH-1:0]   rt_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   alu_in_a,
  output logic [DATA_WIDTH-1:0]   alu_in_b,
  output logic [ALU_OP_WIDTH-1:0] alu_op_type,
  output logic [4:0]              wb_rd,
  output logic                    wb_en,
  output logic                    illegal
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends combinationally on ready, and a presented entry is
  // held unchanged until it transfers.

  issue_entry_t            dec_entry;
  issue_entry_t            buf_q [2];
  issue_entry_t            buf_d [2];
  logic [1:0]              count_q, count_d;
  logic                    head_ok_q, head_ok_d;
  logic [ALU_OP_WIDTH-1:0] last_op_q, last_op_d;
  logic                    in_ready_q, in_ready_d;
  logic                    present;
  logic                    push;
  logic                    pop;

  assign rs_addr = in_instr[25:21];
  assign rt_addr = in_instr[20:16];

  mbscore_inst_decode u_decode (
    .instr_i   (in_instr),
    .rs_data_i (rs_data),
    .rt_data_i (rt_data),
    .entry_o   (dec_entry)
  );

  // head_ok_q marks a head that already had its gap cycle or has been shown, so
  // it keeps being presented even after last_op has caught up with its op.
  assign present = (count_q != 2'd0) && (head_ok_q || (buf_q[0].op != last_op_q));
  assign push    = in_valid && in_ready_q;
  assign pop     = present && out_ready;

  always_comb begin
    buf_d[0] = buf_q[0];
    buf_d[1] = buf_q[1];
    count_d  = count_q;
    if (pop) begin
      buf_d[0] = buf_q[1];
      count_d  = count_q - 2'd1;
    end
    if (push) begin
      if (count_d == 2'd0) buf_d[0] = dec_entry;
      else                 buf_d[1] = dec_entry;
      count_d = count_d + 2'd1;
    end
    head_ok_d  = !pop && (count_q != 2'd0);
    last_op_d  = present ? buf_q[0].op : last_op_q;
    in_ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      count_q    <= 2'd0;
      head_ok_q  <= 1'b0;
      last_op_q  <= ALU_OP_NOP;
      in_ready_q <= 1'b0;
    end else begin
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
      count_q    <= count_d;
      head_ok_q  <= head_ok_d;
      last_op_q  <= last_op_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = present;
  assign alu_in_a    = buf_q[0].a;
  assign alu_in_b    = buf_q[0].b;
  assign alu_op_type = present ? buf_q[0].op : ALU_OP_NOP;
  assign wb_rd       = buf_q[0].rd;
  assign wb_en       = present && buf_q[0].wb_en;
  assign illegal     = present && buf_q[0].illegal;

endmodule

// File: tb/tb_mbscore_alu_issue.sv
// Bench for mbscore_alu_issue: directed test-plan cases, a back-pressure case,
// randomized traffic and a mid-run reset, all checked by a queue scoreboard.
module tb_mbscore_alu_issue;

  typedef logic [79:0] cv_t;
  localparam int EXP_W = 76;
  typedef struct packed {
    logic        rd_care;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        wb;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_in_a;
  logic [31:0] alu_in_b;
  logic [3:0]  alu_op_type;
  logic [4:0]  wb_rd;
  logic        wb_en;
  logic        illegal;

  logic [31:0]      regs [32];
  logic [EXP_W-1:0] exp_q [$];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               acc_cnt  = 0;
  int               ready_mode = 1;
  bit               drv_done;

  logic [5:0] fpool [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                             6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  logic [5:0] ipool [10] = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                             6'h0E, 6'h0F};

  mbscore_alu_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_in_a    (alu_in_a),
    .alu_in_b    (alu_in_b),
    .alu_op_type (alu_op_type),
    .wb_rd       (wb_rd),
    .wb_en       (wb_en),
    .illegal     (illegal)
  );

  assign rs_data = regs[rs_addr];
  assign rt_data = regs[rt_addr];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic chk(input string nm, input cv_t act, input cv_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic exp_t ref_model(input logic [31:0] ins);
    exp_t        e;
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [31:0] rsv, rtv, simm, zimm;
    bit          ok;
    opc  = ins[31:26];
    fn   = ins[5:0];
    rsv  = regs[ins[25:21]];
    rtv  = regs[ins[20:16]];
    simm = {{16{ins[15]}}, ins[15:0]};
    zimm = {16'h0000, ins[15:0]};
    e = '0;
    e.op = 4'd15;
    e.rd_care = 1'b1;
    ok = 1'b1;
    if (opc == 6'h00) begin
      e.rd = ins[15:11];
      e.wb = 1'b1;
      if (fn >= 6'h20 && fn <= 6'h27) begin
        e.op = 4'(fn - 6'h20); e.a = rsv; e.b = rtv;
      end else if (fn == 6'h2A || fn == 6'h2B) begin
        e.op = (fn == 6'h2A) ? 4'd13 : 4'd14; e.a = rsv; e.b = rtv;
      end else if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07}) begin
        e.op = (fn[1:0] == 2'd0) ? 4'd8 : 4'(fn[1:0] + 7);
        e.a  = rtv;
        e.b  = fn[2] ? (rsv & 32'h1F) : 32'(ins[10:6]);
      end else begin
        ok = 1'b0;
      end
    end else if (opc inside {6'h08, 6'h09, 6'h0A, 6'h0B}) begin
      e.a = rsv; e.b = simm; e.rd = ins[20:16]; e.wb = 1'b1;
      e.op = (opc == 6'h08) ? 4'd0 : (opc == 6'h09) ? 4'd1 : (opc == 6'h0A) ? 4'd13 : 4'd14;
    end else if (opc inside {6'h0C, 6'h0D, 6'h0E}) begin
      e.a = rsv; e.b = zimm; e.rd = ins[20:16]; e.wb = 1'b1;
      e.op = 4'(opc - 6'h0C + 4);
    end else if (opc == 6'h0F) begin
      e.a = zimm; e.b = 32'd16; e.op = 4'd8; e.rd = ins[20:16]; e.wb = 1'b1;
    end else if (opc == 6'h04 || opc == 6'h05) begin
      e.a = rsv; e.b = rtv; e.op = (opc == 6'h04) ? 4'd11 : 4'd12; e.rd_care = 1'b0;
    end else begin
      ok = 1'b0;
    end
    if (!ok) begin
      e = '0; e.op = 4'd15; e.ill = 1'b1; e.rd_care = 1'b0;
    end
    if (e.rd == 5'd0) e.wb = 1'b0;
    return e;
  endfunction

  // ---------------- scoreboard monitor ----------------
  exp_t       mon_e;
  exp_t       mon_act;
  int         n_idle;
  bit         presented;
  logic [3:0] prev_op;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_op   = 4'd15;
      presented = 1'b0;
      n_idle    = 0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", cv_t'(out_valid), cv_t'(0));
        end else begin
          mon_e = exp_t'(exp_q[0]);
          if (!presented) begin
            presented = 1'b1;
            chk("gap_cycles", cv_t'(n_idle), cv_t'((mon_e.op == prev_op) ? 1 : 0));
          end
          mon_act = '{rd_care: mon_e.rd_care, a: alu_in_a, b: alu_in_b, op: alu_op_type,
                      rd: wb_rd, wb: wb_en, ill: illegal};
          if (!mon_e.rd_care) mon_act.rd = mon_e.rd;
          chk("issue_entry", cv_t'(mon_act), cv_t'(mon_e));
          if (out_ready) begin
            prev_op = mon_e.op;
            void'(exp_q.pop_front());
            presented = 1'b0;
            n_idle    = 0;
          end
        end
      end else if (exp_q.size() != 0) begin
        n_idle++;
        chk("gap_op_nop", cv_t'(alu_op_type), cv_t'(15));
      end
      if (in_valid && in_ready) begin
        chk("rs_rt_addr", cv_t'({rs_addr, rt_addr}), cv_t'({in_instr[25:21], in_instr[20:16]}));
        exp_q.push_back(EXP_W'(ref_model(in_instr)));
        acc_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] ins);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    in_instr = ins;
    in_valid = 1'b1;
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept_in_time", cv_t'(ok), cv_t'(1));
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", cv_t'(exp_q.size()), cv_t'(0));
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4: begin
        w[31:26] = 6'h00;
        w[5:0]   = fpool[$urandom_range(0, 15)];
        w[15:11] = 5'($urandom_range(0, 7));
      end
      5, 6, 7, 8: w[31:26] = ipool[$urandom_range(0, 9)];
      default: ;
    endcase
    return w;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int acc0;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_instr = 32'h0;
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_outputs",
        cv_t'({out_valid, in_ready, alu_in_a, alu_in_b, alu_op_type, wb_rd, wb_en, illegal}),
        cv_t'({1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 5'h0, 1'b0, 1'b0}));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", cv_t'(in_ready), cv_t'(1));

    // Directed decode and gap cases, back to back with out_ready high.
    send(32'h00221821);
    send(32'h00221821);
    send(32'h00221823);
    send(32'h2022FFFF);
    send(32'h3422FFFF);
    send(32'h3C041234);
    send(32'hFC000000);
    send(32'h00000000);
    wait_drain(100);

    // Back-pressure: three distinct ops while the consumer stalls.
    ready_mode = 0;
    @(posedge clk);
    #1;
    drv_done = 1'b0;
    acc0 = acc_cnt;
    fork
      begin
        send(32'h00222820);
        send(32'h00223025);
        send(32'h00223826);
        drv_done = 1'b1;
      end
    join_none
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("stall_accepts", cv_t'(acc_cnt - acc0), cv_t'(2));
    chk("stall_in_ready", cv_t'(in_ready), cv_t'(0));
    ready_mode = 1;
    n = 0;
    while (!drv_done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stall_driver_done", cv_t'(drv_done), cv_t'(1));
    wait_drain(100);

    // Randomized traffic with random back-pressure.
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    ready_mode = 2;
    for (int k = 0; k < 250; k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      regs[$urandom_range(1, 31)] = $urandom;
      send(gen_instr());
    end
    ready_mode = 1;
    wait_drain(2000);

    // Reset with two entries buffered.
    ready_mode = 0;
    @(posedge clk);
    #1;
    send(32'h00222822);
    send(32'h00223024);
    @(posedge clk);
    #1;
    chk("full_in_ready", cv_t'(in_ready), cv_t'(0));
    #1 rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs",
        cv_t'({out_valid, in_ready, alu_in_a, alu_in_b, alu_op_type, wb_rd, wb_en, illegal}),
        cv_t'({1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 5'h0, 1'b0, 1'b0}));
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 1;
    repeat (6) begin
      @(posedge clk);
      #1;
      chk("post_reset_idle", cv_t'(out_valid), cv_t'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
